// File: rtl/result_display_ctl.sv
// Result display controller: captures each new CPU result into a small circular
// history and shows the selected entry, its index and sticky status on an 8-digit display.
module result_display_ctl #(
   parameter int DATA_WIDTH    = 16,
   parameter int HIST_DEPTH    = 4,
   parameter int REFRESH_COUNT = 100000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic signed [DATA_WIDTH-1:0]  result,
   input  logic                          valid_result,
   input  logic                          error,
   input  logic                          halt,
   input  logic                          browse,
   output logic [7:0]                    an,
   output logic [6:0]                    seg,
   output logic                          dp,
   output logic [$clog2(HIST_DEPTH):0]   hist_count
);

   localparam int PW = $clog2(HIST_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = $clog2(REFRESH_COUNT);

   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_H     = 7'h09;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic                 valid_q;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [PW-1:0]        view_q, view_d;
   logic                 sticky_err_q, sticky_halt_q;
   logic [RW-1:0]        refresh_q;
   logic [2:0]           digit_sel_q;
   logic [7:0]           an_q, an_d;
   logic [6:0]           seg_q, seg_d;
   logic                 dp_q, dp_d;
   logic signed [15:0]   hist_mem [HIST_DEPTH];

   logic signed [15:0]   result_ext;
   logic                 capture;
   logic                 empty;
   logic [CW-1:0]        view_inc;
   logic [PW-1:0]        rd_idx;
   logic signed [15:0]   sel_val;
   logic                 sel_neg;
   logic [15:0]          sel_mag;
   logic [15:0]          mag_shift;

   assign result_ext = result;
   assign capture    = valid_result & ~valid_q;
   assign empty      = (count_q == '0);
   assign view_inc   = {1'b0, view_q} + CW'(1);
   // Newest entry sits just behind the write pointer; view counts backwards from it.
   assign rd_idx     = wr_ptr_q - PW'(1) - view_q;
   assign sel_val    = hist_mem[rd_idx];
   assign sel_neg    = sel_val[15];
   assign sel_mag    = sel_neg ? (16'd0 - sel_val) : sel_val;
   assign mag_shift  = sel_mag >> {digit_sel_q[1:0], 2'b00};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      view_d   = view_q;
      if (capture) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         view_d   = '0;
         if (count_q != CW'(HIST_DEPTH))
            count_d = count_q + CW'(1);
      end else if (browse && !empty) begin
         view_d = (view_inc == count_q) ? '0 : view_inc[PW-1:0];
      end
   end

   always_comb begin
      an_d  = ~(8'd1 << digit_sel_q);
      dp_d  = (digit_sel_q != 3'd5);
      seg_d = SEG_BLANK;
      case (digit_sel_q)
         3'd0, 3'd1, 3'd2, 3'd3: seg_d = empty ? SEG_DASH : hex7(mag_shift[3:0]);
         3'd4:                   seg_d = SEG_BLANK;
         3'd5:                   seg_d = empty ? SEG_BLANK : hex7(4'(view_q));
         3'd6:                   seg_d = (!empty && sel_neg) ? SEG_DASH : SEG_BLANK;
         default:                seg_d = sticky_err_q  ? SEG_E :
                                         sticky_halt_q ? SEG_H : SEG_BLANK;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q       <= 1'b0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         view_q        <= '0;
         sticky_err_q  <= 1'b0;
         sticky_halt_q <= 1'b0;
         refresh_q     <= '0;
         digit_sel_q   <= '0;
         an_q          <= 8'hFF;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
      end else begin
         valid_q       <= valid_result;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         view_q        <= view_d;
         sticky_err_q  <= sticky_err_q | error;
         sticky_halt_q <= sticky_halt_q | halt;
         if (refresh_q == RW'(REFRESH_COUNT - 1)) begin
            refresh_q   <= '0;
            digit_sel_q <= digit_sel_q + 3'd1;
         end else begin
            refresh_q   <= refresh_q + RW'(1);
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   // Stale contents are unreachable once count_q is cleared, so storage needs no reset.
   always_ff @(posedge clk) begin
      if (capture)
         hist_mem[wr_ptr_q] <= result_ext;
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign hist_count = count_q;

endmodule

// File: tb/tb_result_display_ctl.sv
// Directed bench for result_display_ctl: display scan, capture, history browse and sticky flags.
module tb_result_display_ctl;

   localparam int DW = 16;
   localparam int HD = 4;
   localparam int RC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] result = '0;
   logic        valid_result = 1'b0;
   logic        error = 1'b0;
   logic        halt = 1'b0;
   logic        browse = 1'b0;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [2:0]  hist_count;

   int checks = 0;
   int errors = 0;

   result_display_ctl #(
      .DATA_WIDTH(DW), .HIST_DEPTH(HD), .REFRESH_COUNT(RC)
   ) dut (
      .clk(clk), .reset(reset), .result(result), .valid_result(valid_result),
      .error(error), .halt(halt), .browse(browse),
      .an(an), .seg(seg), .dp(dp), .hist_count(hist_count)
   );

   always #5 clk = ~clk;

   // Waits (bounded) until digit d is enabled, then returns its segments and dp.
   task automatic show(input int d, output logic [6:0] s, output logic p);
      logic [7:0] want;
      want = ~(8'd1 << d);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (an === want) begin
            s = seg;
            p = dp;
            $display("digit %0d: seg=%h dp=%b", d, seg, dp);
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL scan_digit%0d an=%h required %h", d, an, want);
      s = seg;
      p = dp;
   endtask

   task automatic capture(input logic [15:0] v);
      @(negedge clk);
      result = v;
      valid_result = 1'b1;
      @(negedge clk);
      valid_result = 1'b0;
      repeat (2) @(negedge clk);
      $display("capture %h -> hist_count=%0d", v, hist_count);
   endtask

   task automatic pulse_browse();
      @(negedge clk);
      browse = 1'b1;
      @(negedge clk);
      browse = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] want_an;
      logic [6:0] want_seg;
      int d;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (an !== 8'hFF) begin errors++; $display("FAIL rst_an an=%h required FF", an); end
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg seg=%h required 7F", seg); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp dp=%b required 1", dp); end
      checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL rst_count count=%0d required 0", hist_count); end
      reset = 1'b0;
      for (int k = 0; k < 8 * RC; k++) begin
         @(negedge clk);
         d = k / RC;
         want_an = ~(8'd1 << d);
         checks++;
         if (an !== want_an) begin errors++; $display("FAIL walk_an step%0d an=%h required %h", k, an, want_an); end
         if (k % RC == 0) begin
            want_seg = (d < 4) ? 7'h3F : 7'h7F;
            $display("walk digit %0d: an=%h seg=%h dp=%b", d, an, seg, dp);
            checks++;
            if (seg !== want_seg) begin errors++; $display("FAIL walk_seg digit%0d seg=%h required %h", d, seg, want_seg); end
            checks++;
            if (dp !== (d != 5)) begin errors++; $display("FAIL walk_dp digit%0d dp=%b required %b", d, dp, (d != 5)); end
         end
      end
      checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL walk_count count=%0d required 0", hist_count); end
   endtask

   task automatic test_hold_capture();
      logic [6:0] exp_seg [7] = '{7'h12, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h7F};
      logic [6:0] s;
      logic p;
      @(negedge clk);
      result = 16'h0005;
      valid_result = 1'b1;
      repeat (5) @(negedge clk);
      valid_result = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (hist_count !== 3'd1) begin errors++; $display("FAIL hold_count count=%0d required 1", hist_count); end
      for (int d = 0; d < 7; d++) begin
         show(d, s, p);
         checks++;
         if (s !== exp_seg[d]) begin errors++; $display("FAIL hold_seg digit%0d seg=%h required %h", d, s, exp_seg[d]); end
      end
   endtask

   task automatic test_negative();
      logic [6:0] exp_seg [7] = '{7'h30, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h3F};
      logic [6:0] s;
      logic p;
      capture(16'hFFFD);
      checks++; if (hist_count !== 3'd2) begin errors++; $display("FAIL neg_count count=%0d required 2", hist_count); end
      for (int d = 0; d < 7; d++) begin
         show(d, s, p);
         checks++;
         if (s !== exp_seg[d]) begin errors++; $display("FAIL neg_seg digit%0d seg=%h required %h", d, s, exp_seg[d]); end
         if (d == 5) begin
            checks++;
            if (p !== 1'b0) begin errors++; $display("FAIL neg_dp5 dp=%b required 0", p); end
         end
      end
   endtask

   task automatic test_history();
      logic [6:0] exp_val [4] = '{7'h19, 7'h30, 7'h24, 7'h12};
      logic [6:0] exp_idx [4] = '{7'h79, 7'h24, 7'h30, 7'h40};
      logic [6:0] s;
      logic p;
      for (int v = 1; v <= 5; v++) capture(16'(v));
      checks++; if (hist_count !== 3'd4) begin errors++; $display("FAIL hist_count count=%0d required 4", hist_count); end
      show(0, s, p);
      checks++; if (s !== 7'h12) begin errors++; $display("FAIL hist_view0 seg=%h required 12", s); end
      for (int b = 0; b < 4; b++) begin
         pulse_browse();
         show(0, s, p);
         checks++;
         if (s !== exp_val[b]) begin errors++; $display("FAIL browse%0d_val seg=%h required %h", b, s, exp_val[b]); end
         show(5, s, p);
         checks++;
         if (s !== exp_idx[b]) begin errors++; $display("FAIL browse%0d_idx seg=%h required %h", b, s, exp_idx[b]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] s;
      logic p;
      pulse_browse();
      pulse_browse();
      show(5, s, p);
      checks++; if (s !== 7'h24) begin errors++; $display("FAIL b2b_pre_idx seg=%h required 24", s); end
      show(0, s, p);
      checks++; if (s !== 7'h30) begin errors++; $display("FAIL b2b_pre_val seg=%h required 30", s); end
      @(negedge clk);
      result = 16'h00A7;
      valid_result = 1'b1;
      browse = 1'b1;
      @(negedge clk);
      valid_result = 1'b0;
      browse = 1'b0;
      repeat (2) @(negedge clk);
      show(5, s, p);
      checks++; if (s !== 7'h40) begin errors++; $display("FAIL b2b_idx seg=%h required 40", s); end
      show(0, s, p);
      checks++; if (s !== 7'h78) begin errors++; $display("FAIL b2b_d0 seg=%h required 78", s); end
      show(1, s, p);
      checks++; if (s !== 7'h08) begin errors++; $display("FAIL b2b_d1 seg=%h required 08", s); end
      checks++; if (hist_count !== 3'd4) begin errors++; $display("FAIL b2b_count count=%0d required 4", hist_count); end
   endtask

   task automatic test_most_negative();
      logic [6:0] s;
      logic p;
      capture(16'h8000);
      show(3, s, p);
      checks++; if (s !== 7'h00) begin errors++; $display("FAIL minneg_d3 seg=%h required 00", s); end
      show(0, s, p);
      checks++; if (s !== 7'h40) begin errors++; $display("FAIL minneg_d0 seg=%h required 40", s); end
      show(6, s, p);
      checks++; if (s !== 7'h3F) begin errors++; $display("FAIL minneg_sign seg=%h required 3F", s); end
   endtask

   task automatic test_sticky();
      logic [6:0] s;
      logic p;
      show(7, s, p);
      checks++; if (s !== 7'h7F) begin errors++; $display("FAIL sticky_init seg=%h required 7F", s); end
      @(negedge clk); error = 1'b1;
      @(negedge clk); error = 1'b0;
      show(7, s, p);
      checks++; if (s !== 7'h06) begin errors++; $display("FAIL sticky_err seg=%h required 06", s); end
      @(negedge clk); halt = 1'b1;
      @(negedge clk); halt = 1'b0;
      repeat (40) @(negedge clk);
      show(7, s, p);
      checks++; if (s !== 7'h06) begin errors++; $display("FAIL sticky_err_hold seg=%h required 06", s); end
      // Assert reset between edges to check the asynchronous clear.
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++; if (an !== 8'hFF) begin errors++; $display("FAIL async_an an=%h required FF", an); end
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL async_seg seg=%h required 7F", seg); end
      checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL async_count count=%0d required 0", hist_count); end
      @(negedge clk);
      reset = 1'b0;
      show(7, s, p);
      checks++; if (s !== 7'h7F) begin errors++; $display("FAIL sticky_cleared seg=%h required 7F", s); end
      show(0, s, p);
      checks++; if (s !== 7'h3F) begin errors++; $display("FAIL hist_discarded seg=%h required 3F", s); end
      @(negedge clk); halt = 1'b1;
      @(negedge clk); halt = 1'b0;
      show(7, s, p);
      checks++; if (s !== 7'h09) begin errors++; $display("FAIL sticky_halt seg=%h required 09", s); end
   endtask

   initial begin
      test_reset();
      test_hold_capture();
      test_negative();
      test_history();
      test_back_to_back();
      test_most_negative();
      test_sticky();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_display_ctl.md
Name: result_display_ctl

Overview:
- Downstream consumer of the stack CPU's nexysA7-facing outputs: `result`, `valid_result`, `error` and `halt`.
- Captures each newly valid ALU result into a small circular history buffer.
- Drives the board's 8-digit multiplexed seven-segment display with the selected result (sign + hex magnitude), the history index and sticky status flags.
- A single-cycle `browse` pulse steps backward through history.

Parameters:
- DATA_WIDTH, 16: width of the signed `result` input. Legal range 4..16; narrower values are sign-extended to 16 internally.
- HIST_DEPTH, 4: number of stored results. Power of two, 2..8.
- REFRESH_COUNT, 100000: clk cycles each digit stays enabled. Minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- result  in  DATA_WIDTH  signed ALU result from CPU
- valid_result  in  1  high while result is valid (may stay high multiple cycles)
- error  in  1  CPU error indication
- halt  in  1  CPU halted indication
- browse  in  1  single-cycle pulse, already synchronized/debounced; selects next-older entry
- an  out  8  digit enables, active-low, one-hot; an[0] = rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- hist_count  out  $clog2(HIST_DEPTH)+1  number of valid entries stored

Behaviour:
- Reset values: an=8'hFF, seg=7'h7F, dp=1, hist_count=0. Refresh counter=0, digit_sel=0, view=0, write pointer=0, sticky_err=0, sticky_halt=0, valid_result_q=0.
- Capture:
  - valid_result_q registers valid_result.
  - Capture occurs on a cycle where valid_result=1 and valid_result_q=0 (rising edge), sampling result that same cycle.
  - A level held high for N cycles captures exactly once.
- History:
  - Circular buffer; each capture writes at the write pointer, which then increments mod HIST_DEPTH.
  - hist_count saturates at HIST_DEPTH.
  - Once full, the oldest entry is overwritten.
  - view=0 means newest entry.
- Browse:
  - browse=1 sets view = (view+1) mod hist_count.
  - Ignored when hist_count=0.
  - A capture forces view=0. If capture and browse occur in the same cycle, the capture wins.
- Sticky flags:
  - sticky_err is set on any cycle error=1; sticky_halt is set on any cycle halt=1.
  - Both flags clear only on reset.
- Refresh:
  - The counter counts 0..REFRESH_COUNT-1.
  - When the counter wraps, digit_sel increments mod 8.
  - an, seg and dp are registered from digit_sel and the current data, so they lag digit_sel by one cycle. The first digit is driven on the first clk after reset deasserts.
- Digit map:
  - Digits 3..0: hex of |selected result| as 16-bit unsigned. The most negative value shows 8000 for DATA_WIDTH=16.
  - Digit 4: blank.
  - Digit 5: view index in hex.
  - Digit 6: '-' if the selected result is negative, else blank.
  - Digit 7: 'E' if sticky_err, else 'H' if sticky_halt, else blank.
  - With hist_count=0: digits 3..0 show '-', and digits 6..5 are blank.
- Segment codes (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - H=09, '-'=3F, blank=7F
- dp is driven low only on digit 5, separating the index from the value; otherwise dp=1.
- Reset mid-refresh: all outputs return to reset values immediately (asynchronously), and history is discarded.

Test Plan:
- Reset, then run 8×REFRESH_COUNT cycles with REFRESH_COUNT=4 and no captures.
  - Required: an walks FE,FD,FB,…,7F.
  - Required: digits 3..0 show seg=3F, digit 7 shows 7F, and hist_count=0.
- Hold valid_result high for 5 cycles with result=16'h0005.
  - Required: exactly one capture, hist_count=1.
  - Required: digit0 seg=12, digits 3..1 seg=40, digit 6 blank.
- Capture result=-3.
  - Required: digit 6 seg=3F; digits 3..0 show 0003 (30,40,40,40).
  - Required: digit 5 shows 0 with dp=0.
- Capture 1,2,3,4,5 with HIST_DEPTH=4.
  - Required: hist_count=4; view0=5.
  - Required: browse ×3 gives views 4,3,2; a 4th browse returns to 5 (1 was overwritten).
- With view=2, assert capture and browse in the same cycle.
  - Required: view=0 and the new value is displayed.
- Pulse error for 1 cycle, then halt.
  - Required: digit 7 shows E (06) and stays E; it clears to blank only after reset.
